// File: rtl/nan_eye_session_ctrl_if.sv
// Link between the NanEye session sequencer and its sampler/deserializer/control neighbours.
// master drives the session inputs; slave is the sequencer itself.
interface nan_eye_session_ctrl_if;
  logic       ENABLE;
  logic       CONFIG_DONE;
  logic       RSYNC;
  logic       FRAME_SYNC_START;
  logic       PAR_DATA_EN;
  logic [7:0] ROW_NUM;
  logic [7:0] COL_NUM;
  logic       DEC_ERROR;

  logic        CONFIG_EN;
  logic        SYNC_START;
  logic        DEC_RSYNC;
  logic        FRAME_START;
  logic        FRAME_DONE;
  logic        ERROR_OUT;
  logic [15:0] FRAME_CNT;
  logic [2:0]  STATE;

  modport master (
    output ENABLE, CONFIG_DONE, RSYNC, FRAME_SYNC_START, PAR_DATA_EN,
           ROW_NUM, COL_NUM, DEC_ERROR,
    input  CONFIG_EN, SYNC_START, DEC_RSYNC, FRAME_START, FRAME_DONE,
           ERROR_OUT, FRAME_CNT, STATE
  );

  modport slave (
    input  ENABLE, CONFIG_DONE, RSYNC, FRAME_SYNC_START, PAR_DATA_EN,
           ROW_NUM, COL_NUM, DEC_ERROR,
    output CONFIG_EN, SYNC_START, DEC_RSYNC, FRAME_START, FRAME_DONE,
           ERROR_OUT, FRAME_CNT, STATE
  );
endinterface

// File: rtl/nan_eye_session_ctrl.sv
// NanEye session sequencer: config, decoder sync, frame capture, timeouts and error retry.
// state      | meaning
// IDLE       | session disabled
// CONFIG     | sensor being configured, waiting for CONFIG_DONE
// SYNC       | decoder resync issued, waiting for first frame sync
// WAIT_FRAME | between frames, waiting for frame sync
// CAPTURE    | counting pixels of a frame
// ERROR      | sync/pixel timeout or too many frame errors
module nan_eye_session_ctrl #(
  parameter int ROWS         = 250,
  parameter int COLS         = 250,
  parameter int SYNC_TIMEOUT = 2000000,
  parameter int PIX_TIMEOUT  = 100000,
  parameter int ERR_LIMIT    = 3
) (
  input  logic                   SCLOCK,
  input  logic                   RESET,
  nan_eye_session_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CONFIG     = 3'd1,
    S_SYNC       = 3'd2,
    S_WAIT_FRAME = 3'd3,
    S_CAPTURE    = 3'd4,
    S_ERROR      = 3'd5
  } state_t;

  localparam logic [15:0] LAST_IDX  = 16'(ROWS * COLS - 1);
  localparam logic [7:0]  ROW_LAST  = 8'(ROWS - 1);
  localparam logic [7:0]  COL_LAST  = 8'(COLS - 1);
  localparam logic [23:0] SYNC_LOAD = 24'(SYNC_TIMEOUT - 1);
  localparam logic [23:0] PIX_LOAD  = 24'(PIX_TIMEOUT - 1);
  localparam logic [7:0]  ERR_LIM   = 8'(ERR_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  cd_sync_q;
  logic        rsync_q;
  logic [23:0] tmr_q;
  logic [15:0] pix_cnt_q;
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  logic go_sync, frame_start, frame_ok, frame_err, pix_inc;
  logic cd_rise, rsync_rise, tmr_zero, last_pixel, count_ok, err_at_limit, fss;

  logic config_en_d, sync_start_d, frame_start_d, frame_done_d, error_out_d;
  logic config_en_q, sync_start_q, dec_rsync_q, frame_start_q, frame_done_q, error_out_q;

  assign fss          = bus.FRAME_SYNC_START;
  assign cd_rise      = cd_sync_q[1] & ~cd_sync_q[2];
  assign rsync_rise   = bus.RSYNC & ~rsync_q;
  assign tmr_zero     = (tmr_q == '0);
  assign last_pixel   = bus.PAR_DATA_EN && (bus.ROW_NUM == ROW_LAST) && (bus.COL_NUM == COL_LAST);
  assign count_ok     = (pix_cnt_q == LAST_IDX);
  assign err_at_limit = ((err_cnt_q + 8'd1) >= ERR_LIM);

  always_ff @(posedge SCLOCK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      config_en_q   <= 1'b0;
      sync_start_q  <= 1'b0;
      dec_rsync_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      error_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      config_en_q   <= config_en_d;
      sync_start_q  <= sync_start_d;
      dec_rsync_q   <= sync_start_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      error_out_q   <= error_out_d;
    end
  end

  // Event flags drive the datapath; later branches only fire if no higher-priority event did.
  always_comb begin
    state_d     = state_q;
    go_sync     = 1'b0;
    frame_start = 1'b0;
    frame_ok    = 1'b0;
    frame_err   = 1'b0;
    pix_inc     = 1'b0;
    if (!bus.ENABLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CONFIG;
        S_CONFIG: begin
          if (cd_rise) begin
            state_d = S_SYNC;
            go_sync = 1'b1;
          end
        end
        S_SYNC, S_WAIT_FRAME: begin
          if (rsync_rise) begin
            state_d = S_SYNC;
            go_sync = 1'b1;
          end else if (tmr_zero) begin
            state_d = S_ERROR;
          end else if (fss) begin
            state_d     = S_CAPTURE;
            frame_start = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (rsync_rise) begin
            state_d = S_SYNC;
            go_sync = 1'b1;
          end else if (bus.DEC_ERROR) begin
            frame_err = 1'b1;
          end else if (tmr_zero) begin
            state_d = S_ERROR;
          end else if (last_pixel && count_ok) begin
            frame_ok = 1'b1;
            if (fss) frame_start = 1'b1;
            else     state_d     = S_WAIT_FRAME;
          end else if (last_pixel || fss) begin
            frame_err = 1'b1;
          end else if (bus.PAR_DATA_EN) begin
            pix_inc = 1'b1;
          end
          if (frame_err) begin
            if (err_at_limit) state_d     = S_ERROR;
            else if (fss)     frame_start = 1'b1;
            else              state_d     = S_WAIT_FRAME;
          end
        end
        S_ERROR: begin
          if (rsync_rise) begin
            state_d = S_SYNC;
            go_sync = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    config_en_d   = (state_d == S_CONFIG);
    sync_start_d  = go_sync;
    frame_start_d = frame_start;
    frame_done_d  = frame_ok;
    error_out_d   = (state_d == S_ERROR);
  end

  // One down-counter serves both the sync/wait window and the inter-pixel gap.
  always_ff @(posedge SCLOCK or posedge RESET) begin
    if (RESET) begin
      cd_sync_q   <= '0;
      rsync_q     <= 1'b0;
      tmr_q       <= '0;
      pix_cnt_q   <= '0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      cd_sync_q <= {cd_sync_q[1:0], bus.CONFIG_DONE};
      rsync_q   <= bus.RSYNC;

      if (frame_start || pix_inc)
        tmr_q <= PIX_LOAD;
      else if (go_sync || (state_d == S_WAIT_FRAME && state_q != S_WAIT_FRAME))
        tmr_q <= SYNC_LOAD;
      else if (!tmr_zero)
        tmr_q <= tmr_q - 24'd1;

      if (frame_start)  pix_cnt_q <= '0;
      else if (pix_inc) pix_cnt_q <= pix_cnt_q + 16'd1;

      if (go_sync || frame_ok) err_cnt_q <= '0;
      else if (frame_err)      err_cnt_q <= err_cnt_q + 8'd1;

      if (frame_ok) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.CONFIG_EN   = config_en_q;
  assign bus.SYNC_START  = sync_start_q;
  assign bus.DEC_RSYNC   = dec_rsync_q;
  assign bus.FRAME_START = frame_start_q;
  assign bus.FRAME_DONE  = frame_done_q;
  assign bus.ERROR_OUT   = error_out_q;
  assign bus.FRAME_CNT   = frame_cnt_q;
  assign bus.STATE       = state_q;

endmodule

// File: tb/tb_nan_eye_session_ctrl.sv
// Directed bench for nan_eye_session_ctrl: a 4x4 instance for sequencing/errors/timeouts
// and a 1x1 instance that streams one-pixel frames to exercise FRAME_CNT wrap.
module tb_nan_eye_session_ctrl;
  logic SCLOCK;
  logic RESET;
  int   n_cmp;
  int   n_bad;

  nan_eye_session_ctrl_if bus();
  nan_eye_session_ctrl_if bus_w();

  nan_eye_session_ctrl #(
    .ROWS(4), .COLS(4), .SYNC_TIMEOUT(50), .PIX_TIMEOUT(20), .ERR_LIMIT(3)
  ) dut (
    .SCLOCK(SCLOCK), .RESET(RESET), .bus(bus)
  );

  nan_eye_session_ctrl #(
    .ROWS(1), .COLS(1), .SYNC_TIMEOUT(50), .PIX_TIMEOUT(20), .ERR_LIMIT(3)
  ) dut_w (
    .SCLOCK(SCLOCK), .RESET(RESET), .bus(bus_w)
  );

  initial SCLOCK = 1'b0;
  always #5 SCLOCK = ~SCLOCK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge SCLOCK);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {bus.CONFIG_EN, bus.SYNC_START, bus.DEC_RSYNC,
            bus.FRAME_START, bus.FRAME_DONE, bus.ERROR_OUT};
  endfunction

  // n strobes rastering a 4x4 frame from (0,0); optional frame sync on the last one
  task automatic raster(input int n, input bit fss_last);
    for (int i = 0; i < n; i++) begin
      bus.PAR_DATA_EN      = 1'b1;
      bus.ROW_NUM          = 8'(i / 4);
      bus.COL_NUM          = 8'(i % 4);
      bus.FRAME_SYNC_START = fss_last && (i == n - 1);
      tick();
    end
    bus.PAR_DATA_EN      = 1'b0;
    bus.FRAME_SYNC_START = 1'b0;
  endtask

  task automatic pulse_fss();
    bus.FRAME_SYNC_START = 1'b1;
    tick();
    bus.FRAME_SYNC_START = 1'b0;
  endtask

  task automatic pulse_rsync();
    bus.RSYNC = 1'b1;
    tick();
    bus.RSYNC = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RESET = 1'b1;
    {bus.ENABLE, bus.CONFIG_DONE, bus.RSYNC, bus.FRAME_SYNC_START,
     bus.PAR_DATA_EN, bus.DEC_ERROR} = '0;
    bus.ROW_NUM = '0;
    bus.COL_NUM = '0;
    {bus_w.ENABLE, bus_w.CONFIG_DONE, bus_w.RSYNC, bus_w.FRAME_SYNC_START,
     bus_w.PAR_DATA_EN, bus_w.DEC_ERROR} = '0;
    bus_w.ROW_NUM = '0;
    bus_w.COL_NUM = '0;
    tick(2);
    check_eq("rst_state", 32'(bus.STATE), 0);
    check_eq("rst_outs", 32'(outs()), 0);
    check_eq("rst_fcnt", 32'(bus.FRAME_CNT), 0);
    RESET = 1'b0;

    bus.ENABLE = 1'b1;
    tick();
    check_eq("cfg_state", 32'(bus.STATE), 1);
    check_eq("cfg_en", 32'(outs()), 32'h20);
    pulse_rsync();
    check_eq("cfg_rsync_ignored", 32'(bus.STATE), 1);

    bus.CONFIG_DONE = 1'b1;
    tick();
    check_eq("cd_edge1", 32'(bus.STATE), 1);
    tick();
    check_eq("cd_edge2", 32'(bus.STATE), 1);
    tick();
    check_eq("cd_edge3_state", 32'(bus.STATE), 2);
    check_eq("cd_edge3_outs", 32'(outs()), 32'h18);
    tick();
    check_eq("sync_pulse_end", 32'(outs()), 0);

    pulse_fss();
    check_eq("fs_state", 32'(bus.STATE), 4);
    check_eq("fs_start", 32'(outs()), 32'h04);
    for (int i = 0; i < 16; i++) begin
      bus.PAR_DATA_EN = 1'b1;
      bus.ROW_NUM     = 8'(i / 4);
      bus.COL_NUM     = 8'(i % 4);
      tick();
      check_eq($sformatf("done_strobe%0d", i), 32'(bus.FRAME_DONE), (i == 15) ? 1 : 0);
    end
    bus.PAR_DATA_EN = 1'b0;
    check_eq("f1_cnt", 32'(bus.FRAME_CNT), 1);
    check_eq("f1_state", 32'(bus.STATE), 3);
    tick();
    check_eq("f1_done_end", 32'(bus.FRAME_DONE), 0);

    pulse_fss();
    check_eq("e_cap_state", 32'(bus.STATE), 4);
    for (int k = 0; k < 3; k++) begin
      raster(5, 1'b0);
      pulse_fss();
      check_eq($sformatf("err%0d_state", k), 32'(bus.STATE), (k < 2) ? 4 : 5);
      check_eq($sformatf("err%0d_outs", k), 32'(outs()), (k < 2) ? 32'h04 : 32'h01);
    end
    pulse_rsync();
    check_eq("err_rsync_state", 32'(bus.STATE), 2);
    check_eq("err_rsync_outs", 32'(outs()), 32'h18);

    tick(49);
    check_eq("sto_49", 32'(bus.STATE), 2);
    tick();
    check_eq("sto_50_state", 32'(bus.STATE), 5);
    check_eq("sto_50_err", 32'(bus.ERROR_OUT), 1);

    pulse_rsync();
    pulse_fss();
    raster(3, 1'b0);
    tick(19);
    check_eq("pto_19", 32'(bus.STATE), 4);
    tick();
    check_eq("pto_20", 32'(bus.STATE), 5);

    pulse_rsync();
    pulse_fss();
    raster(16, 1'b1);
    check_eq("both_outs", 32'(outs()), 32'h06);
    check_eq("both_state", 32'(bus.STATE), 4);
    check_eq("both_cnt", 32'(bus.FRAME_CNT), 2);
    raster(16, 1'b0);
    check_eq("next_state", 32'(bus.STATE), 3);
    check_eq("next_cnt", 32'(bus.FRAME_CNT), 3);

    bus.DEC_ERROR = 1'b1;
    tick();
    bus.DEC_ERROR = 1'b0;
    check_eq("wait_decerr_ignored", 32'(bus.STATE), 3);

    for (int f = 0; f < 4; f++) begin
      pulse_fss();
      raster(16, 1'b0);
    end
    check_eq("cnt7", 32'(bus.FRAME_CNT), 7);

    pulse_fss();
    raster(5, 1'b0);
    bus.ENABLE           = 1'b0;
    bus.FRAME_SYNC_START = 1'b1;
    tick();
    bus.FRAME_SYNC_START = 1'b0;
    check_eq("dis_state", 32'(bus.STATE), 0);
    check_eq("dis_outs", 32'(outs()), 0);
    check_eq("dis_cnt", 32'(bus.FRAME_CNT), 7);
    bus.ENABLE = 1'b1;
    tick();
    check_eq("reen_state", 32'(bus.STATE), 1);
    check_eq("reen_cnt", 32'(bus.FRAME_CNT), 7);

    bus_w.ENABLE = 1'b1;
    tick();
    bus_w.CONFIG_DONE = 1'b1;
    tick(3);
    check_eq("w_sync", 32'(bus_w.STATE), 2);
    bus_w.FRAME_SYNC_START = 1'b1;
    tick();
    check_eq("w_cap", 32'(bus_w.STATE), 4);
    bus_w.PAR_DATA_EN = 1'b1;
    tick(65535);
    check_eq("w_cnt_ffff", 32'(bus_w.FRAME_CNT), 32'hFFFF);
    check_eq("w_state_cap", 32'(bus_w.STATE), 4);
    bus_w.FRAME_SYNC_START = 1'b0;
    tick();
    bus_w.PAR_DATA_EN = 1'b0;
    check_eq("w_wrap_cnt", 32'(bus_w.FRAME_CNT), 0);
    check_eq("w_wrap_done", 32'(bus_w.FRAME_DONE), 1);
    check_eq("w_wrap_state", 32'(bus_w.STATE), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
